muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the ALU's multiply/divide unit (function codes 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU).
- Iterates a 32-step shift-add multiplier or restoring divider over one shared 64-bit working register.
- Owns the architectural HI/LO registers and provides a start/busy/done handshake so the pipeline can stall on HI/LO reads.

Parameters:
- WIDTH, 32, operand width; HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request operation; sampled only in IDLE.
- alufunc  in  4  operation code; only 11xx accepted.
- dataa  in  32  multiplicand / dividend.
- datab  in  32  multiplier / divisor.
- cancel  in  1  pipeline flush; aborts an in-flight operation.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  32  MTHI/MTLO write data.
- busy  out  1  operation in flight; pipeline stalls HI/LO access.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- divz  out  1  latched divide-by-zero flag of the last divide.
- hi  out  32  HI register: product[63:32] or remainder.
- lo  out  32  LO register: product[31:0] or quotient.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset has priority over everything.
- Reset values: state=IDLE, busy=0, done=0, divz=0, hi=0, lo=0, counter=0.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, 32 cycles.
  - FIX: busy=1, 1 cycle.
  - Transitions: IDLE→CALC on start && alufunc[3:2]==2'b11. CALC→FIX when counter reaches 0. FIX→IDLE always.
  - start with alufunc[3:2]!=2'b11 is ignored (stays IDLE, no done).
- Accept edge (IDLE→CALC):
  - Latch the op code.
  - For signed ops (alufunc[0]==0), latch operand magnitudes plus sign bits.
  - Load counter=31.
- CALC:
  - One multiply add-shift or one restoring-divide subtract-shift step per cycle on unsigned magnitudes.
  - Counter decrements each cycle.
- FIX edge:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo; set done=1 for exactly the next cycle.
- Latency: start sampled at edge 0 → busy=1 in cycles 1..33 → cycle 34 has busy=0, done=1, new hi/lo visible.
  - start may be reasserted in the done cycle and is accepted.
- start while busy: ignored; no queuing.
- Divide by zero (datab==0, DIV or DIVU):
  - The op still runs the full 34 cycles.
  - Result is lo=32'hFFFFFFFF, hi=dataa regardless of signedness.
  - divz=1 from the done cycle onward.
  - divz is cleared at the accept edge of any later op.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0, divz=0.
- cancel:
  - In CALC/FIX, return to IDLE at the next edge; no done; hi/lo/divz unchanged.
  - cancel has priority over FIX completion.
  - cancel in IDLE together with start: start is dropped.
- hi_we/lo_we:
  - Write wdata to hi/lo only in IDLE with start not accepted that cycle.
  - Ignored while busy; the pipeline is responsible for stalling.
  - If start is accepted in the same cycle, the write is dropped.
  - hi_we and lo_we together: both registers take wdata.
- hi/lo hold their value between operations; changed only by FIX, writes, or reset.

Test Plan:
- MULTU dataa=32'hFFFFFFFF, datab=32'hFFFFFFFF, start at edge 0 → busy cycles 1..33; cycle 34 done=1, hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT dataa=-3 (32'hFFFFFFFD), datab=5 → hi=32'hFFFFFFFF, lo=32'hFFFFFFF1, divz=0.
- DIV dataa=-7, datab=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU dataa=100, datab=7 → lo=14, hi=2.
- DIVU dataa=32'h12345678, datab=0 → done at cycle 34, lo=32'hFFFFFFFF, hi=32'h12345678, divz=1. Then MULTU 2×3 → divz=0 at accept, hi=0, lo=6.
- Cancel scenario:
  - MULT started; cancel at cycle 10 → cycle 11 busy=0, no done pulse, hi/lo keep prior values.
  - start asserted at cycle 5 of a busy op → ignored; exactly one done.
- Register writes and reset:
  - hi_we=1, wdata=32'hA5A5A5A5 in IDLE → hi updates next cycle.
  - lo_we while busy → lo unchanged.
  - reset at cycle 20 of a DIV → next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH working register.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alufunc,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   raw_a;
  logic [CNT_W-1:0]   counter;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;

  logic               accept;
  logic               is_signed;
  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept    = (state == IDLE) && start && (alufunc[3:2] == 2'b11) && !cancel;
  assign is_signed = !alufunc[0];
  assign in_sign_a = is_signed && dataa[WIDTH-1];
  assign in_sign_b = is_signed && datab[WIDTH-1];
  assign in_mag_a  = in_sign_a ? (~dataa + {{(WIDTH-1){1'b0}}, 1'b1}) : dataa;
  assign in_mag_b  = in_sign_b ? (~datab + {{(WIDTH-1){1'b0}}, 1'b1}) : datab;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; cancel beats both iteration and completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = CALC;
        else        state_nxt = IDLE;
      end
      CALC: begin
        if (cancel)                           state_nxt = IDLE;
        else if (counter == {CNT_W{1'b0}})    state_nxt = FIX;
        else                                  state_nxt = CALC;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step of each algorithm on the unsigned magnitudes
  always_comb begin
    if (work[0]) begin
      mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, mag_b};
    end else begin
      mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]};
    end
    mul_next  = {mul_sum, work[WIDTH-1:1]};
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    div_ok    = !div_diff[WIDTH+1];
    if (div_ok) begin
      div_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied at completion
  always_comb begin
    if (sign_a ^ sign_b) begin
      prod_fix = ~work + {{(2*WIDTH-1){1'b0}}, 1'b1};
      quot_fix = ~work[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      prod_fix = work;
      quot_fix = work[WIDTH-1:0];
    end
    if (sign_a) begin
      rem_fix = ~work[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rem_fix = work[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      work    <= {(2*WIDTH){1'b0}};
      mag_b   <= {WIDTH{1'b0}};
      raw_a   <= {WIDTH{1'b0}};
      counter <= {CNT_W{1'b0}};
      op_div  <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_zero  <= 1'b0;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      done    <= 1'b0;
      divz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            work    <= {{WIDTH{1'b0}}, in_mag_a};
            mag_b   <= in_mag_b;
            raw_a   <= dataa;
            op_div  <= alufunc[1];
            sign_a  <= in_sign_a;
            sign_b  <= in_sign_b;
            b_zero  <= (datab == {WIDTH{1'b0}});
            counter <= CNT_W'(WIDTH - 1);
            divz    <= 1'b0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (!cancel) begin
            work <= op_div ? div_next : mul_next;
            if (counter != {CNT_W{1'b0}}) counter <= counter - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (!op_div) begin
              hi   <= prod_fix[2*WIDTH-1:WIDTH];
              lo   <= prod_fix[WIDTH-1:0];
              divz <= 1'b0;
            end else if (b_zero) begin
              // Divide by zero reports all-ones quotient and the raw dividend
              hi   <= raw_a;
              lo   <= {WIDTH{1'b1}};
              divz <= 1'b1;
            end else begin
              hi   <= rem_fix;
              lo   <= quot_fix;
              divz <= 1'b0;
            end
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, corner sequences, random ops vs model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, cancel, hi_we, lo_we;
  logic [3:0]  alufunc;
  logic [31:0] dataa, datab, wdata;
  logic        busy, done, divz;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] cur_hi, cur_lo;
  logic        cur_divz;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .alufunc(alufunc),
    .dataa(dataa), .datab(datab), .cancel(cancel), .hi_we(hi_we),
    .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .divz(divz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural meaning of each op
  task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic d);
    longint sa, sb, p;
    logic [63:0] up;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = int'(a);
    ib = int'(b);
    d = 1'b0;
    if (!f[1]) begin
      if (!f[0]) begin
        p = sa * sb;
        up = 64'(p);
      end else begin
        up = {32'h0, a} * {32'h0, b};
      end
      h = up[63:32];
      l = up[31:0];
    end else if (b == 32'h0) begin
      h = a;
      l = 32'hFFFFFFFF;
      d = 1'b1;
    end else if (!f[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        l = 32'h80000000;
        h = 32'h0;
      end else begin
        l = 32'(ia / ib);
        h = 32'(ia % ib);
      end
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  // Start an op at the current cycle and check the full handshake through the done cycle
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int bad;
    start = 1'b1; alufunc = f; dataa = a; datab = b;
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    chk("busy_window", 32'(bad), 32'd0);
    chk("done_pulse", {31'h0, done}, 32'd1);
    chk("busy_in_done", {31'h0, busy}, 32'd0);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("divz", {31'h0, divz}, {31'h0, ed});
    cur_hi = eh; cur_lo = el; cur_divz = ed;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eh, el;
    logic        ed;
    logic [3:0]  f;
    logic [31:0] a, b;
    int dcount;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    alufunc = 4'h0; dataa = 32'h0; datab = 32'h0; wdata = 32'h0;
    step(); step();
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_divz", {31'h0, divz}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b0;
    step();

    vecs.push_back('{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{4'b1100, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{4'b1110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{4'b1111, 32'd100,      32'd7,        32'd2,        32'd14,        1'b0});
    vecs.push_back('{4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{4'b1110, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{4'b1100, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{4'b1110, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD,  1'b0});
    vecs.push_back('{4'b1101, 32'h0,        32'h00012345, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{4'b1111, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1});
    // Back-to-back: each op starts in the previous op's done cycle
    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].ed);

    // divz from the last divide-by-zero clears at the next accept
    start = 1'b1; alufunc = 4'b1101; dataa = 32'd2; datab = 32'd3;
    step();
    start = 1'b0;
    chk("divz_clr_at_accept", {31'h0, divz}, 32'd0);
    repeat (33) step();
    chk("mul23_done", {31'h0, done}, 32'd1);
    chk("mul23_hi", hi, 32'd0);
    chk("mul23_lo", lo, 32'd6);
    cur_hi = 32'd0; cur_lo = 32'd6;

    // Cancel at cycle 10 of a MULT
    start = 1'b1; alufunc = 4'b1100; dataa = 32'h1234; datab = 32'h5678;
    step();
    start = 1'b0;
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_busy", {31'h0, busy}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcount++;
      step();
    end
    chk("cancel_no_done", 32'(dcount), 32'd0);
    chk("cancel_hi", hi, cur_hi);
    chk("cancel_lo", lo, cur_lo);

    // Cancel in the FIX cycle suppresses completion
    start = 1'b1; alufunc = 4'b1111; dataa = 32'd50; datab = 32'd5;
    step();
    start = 1'b0;
    repeat (32) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("fix_cancel_done", {31'h0, done}, 32'd0);
    chk("fix_cancel_lo", lo, cur_lo);

    // Cancel together with start in IDLE drops the start
    start = 1'b1; cancel = 1'b1; alufunc = 4'b1101;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_drop", {31'h0, busy}, 32'd0);

    // Non-11xx function code is ignored
    start = 1'b1; alufunc = 4'b0110;
    step();
    start = 1'b0;
    chk("bad_func_busy", {31'h0, busy}, 32'd0);

    // Start while busy is ignored: exactly one done with the first op's result
    start = 1'b1; alufunc = 4'b1101; dataa = 32'd9; datab = 32'd11;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; alufunc = 4'b1101; dataa = 32'd1000; datab = 32'd1000;
    step();
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) dcount++;
      step();
    end
    chk("one_done", 32'(dcount), 32'd1);
    chk("first_op_lo", lo, 32'd99);
    cur_hi = 32'd0; cur_lo = 32'd99;

    // MTHI in IDLE
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    step();
    hi_we = 1'b0;
    chk("mthi", hi, 32'hA5A5A5A5);
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0BADF00D;
    step();
    lo_we = 1'b0; hi_we = 1'b0;
    chk("both_we_hi", hi, 32'h0BADF00D);
    chk("both_we_lo", lo, 32'h0BADF00D);
    cur_hi = 32'h0BADF00D; cur_lo = 32'h0BADF00D;

    // Write dropped when start is accepted the same cycle; MTLO ignored while busy
    start = 1'b1; alufunc = 4'b1101; dataa = 32'd4; datab = 32'd5; lo_we = 1'b1; wdata = 32'h11111111;
    step();
    start = 1'b0;
    chk("we_with_accept", lo, cur_lo);
    repeat (2) step();
    lo_we = 1'b1; wdata = 32'h22222222;
    step();
    lo_we = 1'b0;
    chk("we_while_busy", lo, cur_lo);
    repeat (30) step();
    chk("after_we_done", {31'h0, done}, 32'd1);
    chk("after_we_lo", lo, 32'd20);

    // Reset at cycle 20 of a DIV
    start = 1'b1; alufunc = 4'b1110; dataa = 32'd77; datab = 32'd0;
    step();
    start = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'h0);
    chk("mid_rst_lo", lo, 32'h0);
    chk("mid_rst_divz", {31'h0, divz}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dcount++;
      step();
    end
    chk("mid_rst_no_done", 32'(dcount), 32'd0);

    // Random ops against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      f = 4'b1100 | 4'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 20));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: b = b;
      endcase
      model(f, a, b, eh, el, ed);
      run_op(f, a, b, eh, el, ed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
